// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator: decodes the immediate and pc+imm target,
// then holds results in a 2-entry skid buffer (main drives outputs, skid absorbs stalls).
module imm_gen_pipe #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [D_WIDTH-1:0] pc,
  input  logic [2:0]         ImmSrc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] imm_out,
  output logic [D_WIDTH-1:0] target_out,
  output logic [2:0]         fmt_out,
  output logic               illegal_out
);

  localparam logic [2:0] FMT_NONE  = 3'b000;
  localparam logic [2:0] FMT_I     = 3'b001;
  localparam logic [2:0] FMT_S     = 3'b010;
  localparam logic [2:0] FMT_B     = 3'b011;
  localparam logic [2:0] FMT_U     = 3'b100;
  localparam logic [2:0] FMT_J     = 3'b101;
  localparam logic [2:0] FMT_SHAMT = 3'b110;
  localparam logic [2:0] FMT_AUTO  = 3'b111;

  typedef struct packed {
    logic [D_WIDTH-1:0] imm;
    logic [D_WIDTH-1:0] target;
    logic [2:0]         fmt;
    logic               illegal;
  } entry_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [2:0]         dec_fmt;
  logic               dec_illegal;
  logic [31:0]        imm32;
  logic [D_WIDTH-1:0] imm_ext;
  entry_t             dec_entry;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    dec_fmt     = ImmSrc;
    dec_illegal = 1'b0;
    if (ImmSrc == FMT_AUTO) begin
      dec_fmt = FMT_NONE;
      case (opcode)
        7'b0010011: dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
        7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
        7'b0100011: dec_fmt = FMT_S;
        7'b1100011: begin
          dec_fmt     = FMT_B;
          dec_illegal = (funct3 == 3'b010 || funct3 == 3'b011);
        end
        7'b0110111, 7'b0010111: dec_fmt = FMT_U;
        7'b1101111: dec_fmt = FMT_J;
        7'b0110011: dec_fmt = FMT_NONE;
        default:    dec_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    imm32 = 32'd0;
    case (dec_fmt)
      FMT_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:     imm32 = {instr[31:12], 12'd0};
      FMT_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: imm32 = {27'd0, instr[24:20]};
      default:   imm32 = 32'd0;
    endcase
  end

  // Widen from bit 31 of the 32-bit immediate; shamt has bit 31 clear so it stays zero-extended.
  always_comb begin
    imm_ext       = {D_WIDTH{imm32[31]}};
    imm_ext[31:0] = imm32;
    if (dec_illegal) imm_ext = '0;
  end

  always_comb begin
    dec_entry.imm     = imm_ext;
    dec_entry.target  = dec_illegal ? '0 : pc + imm_ext;
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
  end

  // Handshake: a word moves on any edge where valid && ready are both high;
  // valid never depends on ready, and a stalled output holds its fields unchanged.
  entry_t main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   take_in, drain;

  assign take_in = in_valid && in_ready;
  assign drain   = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!main_valid || drain) begin
      // in_ready is low whenever skid is full, so no input can arrive alongside the skid move.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (take_in) begin
        main_q     <= dec_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
      in_ready <= 1'b1;
    end else if (take_in) begin
      skid_q     <= dec_entry;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign out_valid   = main_valid;
  assign imm_out     = main_q.imm;
  assign target_out  = main_q.target;
  assign fmt_out     = main_q.fmt;
  assign illegal_out = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, flush, out_ready;
  logic [31:0] instr;
  logic [2:0]  src;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, target32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64, target64;
  logic [2:0]  fmt64;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.D_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .pc(pc32), .ImmSrc(src), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm32),
    .target_out(target32), .fmt_out(fmt32), .illegal_out(ill32)
  );

  imm_gen_pipe #(.D_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .pc(pc64), .ImmSrc(src), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_out(imm64),
    .target_out(target64), .fmt_out(fmt64), .illegal_out(ill64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One word through an empty, non-stalled pipe; returns #1 after the accepting edge.
  task automatic send_one(input logic [31:0] i, input logic [63:0] p, input logic [2:0] s);
    @(negedge clk);
    instr    = i;
    pc32     = p[31:0];
    pc64     = p;
    src      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    out_ready = 1'b0;
    instr     = a;
    src       = 3'b111;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    instr = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n_seen;
    logic c_taken;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    src       = '0;
    pc32      = '0;
    pc64      = '0;
    #1 rst_n = 1'b0;
    #10;
    check("rst_out_valid", out_valid32, 0);
    check("rst_in_ready", in_ready32, 1);
    check("rst_imm", imm32, 0);
    check("rst_target", target32, 0);
    check("rst_fmt", fmt32, 0);
    check("rst_illegal", ill32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_one(32'hFFF00093, 64'h200, 3'b111);
    check("i_valid", out_valid32, 1);
    check("i_imm", imm32, 32'hFFFFFFFF);
    check("i_target", target32, 32'h1FF);
    check("i_fmt", fmt32, 3'b001);
    check("i_illegal", ill32, 0);

    send_one(32'hFE000EE3, 64'h100, 3'b111);
    check("b_imm", imm32, 32'hFFFFFFFC);
    check("b_target", target32, 32'hFC);
    check("b_fmt", fmt32, 3'b011);

    send_one(32'h008000EF, 64'h0, 3'b111);
    check("j_imm", imm32, 32'd8);
    check("j_fmt", fmt32, 3'b101);

    send_one(32'h123450B7, 64'h0, 3'b111);
    check("u_imm", imm32, 32'h12345000);
    check("u_fmt", fmt32, 3'b100);

    send_one(32'h01F01093, 64'h0, 3'b111);
    check("shamt_imm", imm32, 32'd31);
    check("shamt_fmt", fmt32, 3'b110);

    send_one(32'h0000007F, 64'h40, 3'b111);
    check("ill_flag", ill32, 1);
    check("ill_imm", imm32, 0);
    check("ill_target", target32, 0);

    send_one(32'h00002063, 64'h40, 3'b111);
    check("b_f3_ill_flag", ill32, 1);
    check("b_f3_ill_imm", imm32, 0);

    send_one(32'h002081B3, 64'h80, 3'b111);
    check("rtype_fmt", fmt32, 3'b000);
    check("rtype_illegal", ill32, 0);
    check("rtype_target", target32, 32'h80);

    send_one(32'hFFF00093, 64'h20, 3'b010);
    check("expl_s_imm", imm32, 32'hFFFFFFE1);
    check("expl_s_target", target32, 32'h1);
    check("expl_s_fmt", fmt32, 3'b010);

    send_one(32'h0000007F, 64'h20, 3'b000);
    check("expl_none_illegal", ill32, 0);
    check("expl_none_imm", imm32, 0);

    send_one(32'h800000B7, 64'h1000, 3'b111);
    check("w64_imm", imm64, 64'hFFFFFFFF80000000);
    check("w64_target", target64, 64'hFFFFFFFF80001000);
    check("w32_u_imm", imm32, 32'h80000000);
    check("w32_u_target", target32, 32'h80001000);
    @(posedge clk);
    #1;
    check("drained_valid", out_valid32, 0);

    // Backpressure: A and B held, C waits, then all three drain in order.
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    fill_two(32'h00100093, 32'h00200093);
    check("bp_in_ready_low", in_ready32, 0);
    check("bp_head_a", imm32, 32'd1);
    instr = 32'h00300093;
    @(posedge clk);
    #1;
    check("bp_c_blocked", in_ready32, 0);
    check("bp_head_stable", imm32, 32'd1);
    check("bp_valid_held", out_valid32, 1);
    out_ready = 1'b1;
    n_seen    = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid32) begin
        n_seen++;
        if (exp_q.size() == 0) check("bp_extra_output", imm32, 32'hDEAD);
        else check("bp_order", imm32, exp_q.pop_front());
      end
      c_taken = in_valid && in_ready32;
      @(posedge clk);
      #1;
      if (c_taken) in_valid = 1'b0;
    end
    check("bp_c_accepted", in_valid, 0);
    check("bp_count", n_seen, 3);
    check("bp_queue_empty", exp_q.size(), 0);

    // Flush with a full buffer and a word offered on the same edge.
    fill_two(32'h00100093, 32'h00200093);
    instr = 32'h00700093;
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_full_valid", out_valid32, 0);
    check("flush_full_ready", in_ready32, 1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_seen    = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid32) n_seen++;
    end
    check("flush_full_nothing", n_seen, 0);

    // Flush drops a transfer into an empty pipe.
    @(negedge clk);
    instr    = 32'h00700093;
    src      = 3'b111;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    check("flush_drop_valid", out_valid32, 0);
    check("flush_drop_ready", in_ready32, 1);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a stall.
    pc64 = 64'h1000;
    fill_two(32'h800000B7, 32'h800000B7);
    check("pre_rst_ready", in_ready64, 0);
    check("pre_rst_imm64", imm64, 64'hFFFFFFFF80000000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid64", out_valid64, 0);
    check("arst_ready64", in_ready64, 1);
    check("arst_imm64", imm64, 0);
    check("arst_target64", target64, 0);
    check("arst_fmt64", fmt64, 0);
    check("arst_ill64", ill64, 0);
    check("arst_valid32", out_valid32, 0);
    check("arst_ready32", in_ready32, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid64, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I datapath. It sits between fetch and execute. It accepts one instruction word per cycle over a valid/ready handshake and emits registered outputs:
- the sign- or zero-extended immediate, widened to `D_WIDTH`;
- the decoded immediate format;
- an illegal-opcode flag;
- the precomputed `pc + imm` target.

A 2-entry skid buffer lets downstream stalls propagate without dropping or duplicating instructions. A flush input discards in-flight work on branch redirect.

## Interface
- `D_WIDTH`, 32, width of `pc`, `imm_out` and `target_out`; legal values are 32 and 64; sign extension always comes from `instr[31]`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  block can accept; registered
- `instr`  in  32  instruction word
- `pc`  in  D_WIDTH  address of `instr`
- `ImmSrc`  in  3  format select: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J, 110 I-shamt, 111 auto-decode
- `flush`  in  1  discard all buffered entries
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  downstream accepts
- `imm_out`  out  D_WIDTH  extended immediate
- `target_out`  out  D_WIDTH  `pc + imm_out`, modulo 2^D_WIDTH
- `fmt_out`  out  3  resolved format, same encoding as `ImmSrc` 000–110
- `illegal_out`  out  1  auto-decode found an unsupported opcode or funct3

## Operation

**Format decode** (combinational, before the buffer):
- none: 0
- I: `{instr[31]…, instr[31:20]}`
- S: `{instr[31]…, instr[31:25], instr[11:7]}`
- B: `{instr[31]…, instr[7], instr[30:25], instr[11:8], 0}`
- U: `{instr[31]…, instr[31:12], 12'b0}`; sign-extended above bit 31 when `D_WIDTH` = 64
- J: `{instr[31]…, instr[19:12], instr[20], instr[30:21], 0}`
- I-shamt: zero-extended `instr[24:20]`

**Auto-decode** (`ImmSrc` = 111), by opcode:
- 0010011: funct3 001/101 → I-shamt; otherwise → I
- 0000011, 1100111, 1110011 → I
- 0100011 → S
- 1100011 → B; funct3 010/011 → illegal
- 0110111, 0010111 → U
- 1101111 → J
- 0110011 → none, not illegal
- any other opcode → none, imm 0, illegal

**Illegal flag:** explicit `ImmSrc` values never set `illegal_out`. When an entry is illegal, `imm_out` and `target_out` are 0.

**Skid buffer:**
- Holds a main register (drives the outputs) and a skid register.
- A transfer happens when `in_valid && in_ready`. The entry goes to main if main is empty or draining this cycle; otherwise it goes to skid.
- When main drains and skid is full, skid moves into main on the same edge.
- `in_ready` is registered and equals "skid empty after this edge".
- Order is strictly FIFO.

**Flush:** on an edge where `flush` = 1:
- both entries are invalidated;
- a simultaneous input transfer is dropped;
- `in_ready` becomes 1.

**Reset:** reset is asynchronous, at any time, including mid-stall.
- `out_valid`, `imm_out`, `target_out`, `fmt_out` and `illegal_out` reset to 0.
- `in_ready` resets to 1.
- Both buffer entries are cleared.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`, when main is empty.
- Throughput is 1 instruction per cycle while `out_ready` = 1.
- Output fields are stable while `out_valid && !out_ready`.
- With `out_ready` = 0, the block accepts exactly 2 entries. `in_ready` falls on the edge that fills skid.
- `in_ready` returns to 1 one edge after main drains.
- Flush has priority over every transfer on the same edge.

## Test plan
- **Auto I-type:** `ImmSrc` = 111, `instr` = 0xFFF00093, `pc` = 0x200 → next cycle `imm_out` = 0xFFFFFFFF, `target_out` = 0x1FF, `fmt_out` = 001, `illegal_out` = 0.
- **B and J formats, auto:**
  - `instr` = 0xFE000EE3, `pc` = 0x100 → `imm_out` = 0xFFFFFFFC, `target_out` = 0xFC, `fmt_out` = 011.
  - `instr` = 0x008000EF → `imm_out` = 8.
- **U, shamt and illegal:**
  - `instr` = 0x123450B7 → `imm_out` = 0x12345000.
  - `instr` = 0x01F01093 → `imm_out` = 31, `fmt_out` = 110.
  - `instr` = 0x0000007F → `illegal_out` = 1, `imm_out` = 0.
- **Backpressure:**
  - Hold `out_ready` = 0 and present A, B, C back-to-back → A and B accepted, `in_ready` = 0 while C is held.
  - Raise `out_ready` → A, B, C emerge in order, one per cycle, with no duplicates.
- **Flush with a full buffer:** assert `flush` together with `in_valid` → next cycle `out_valid` = 0 and `in_ready` = 1; the dropped word never appears.
- **`D_WIDTH` = 64 and reset:**
  - `instr` = 0x800000B7 → `imm_out` = 0xFFFFFFFF80000000.
  - Assert `rst_n` = 0 mid-stall → all outputs 0 immediately and `in_ready` = 1.
